// File: rtl/product_accumulator.sv
// Saturating frame accumulator: sums a programmable number of 16-bit products
// and presents each frame sum on a valid/ready output handshake.
module product_accumulator #(
  parameter int unsigned ACC_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      prod_in,
  input  logic             prod_valid,
  output logic             prod_ready,
  input  logic [7:0]       frame_len,
  input  logic             clear,
  output logic [ACC_W-1:0] sum_out,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             sat
);

  localparam int unsigned SUM_W = ACC_W + 1;
  localparam int unsigned CNT_W = 9;
  localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

  typedef enum logic {ACCUM, HOLD} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   term_cnt_q, term_cnt_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [ACC_W-1:0]   sum_out_q, sum_out_d;
  logic               sum_valid_q, sum_valid_d;
  logic               sat_q, sat_d;
  logic               sat_acc_q, sat_acc_d;

  logic               accept;
  logic [CNT_W-1:0]   len_frame;
  logic [CNT_W-1:0]   len_eff;
  logic [SUM_W-1:0]   sum_w;
  logic               ovf;
  logic [ACC_W-1:0]   next_acc;
  logic               last_term;

  // Datapath: one extra bit catches overflow, which is clamped instead of wrapping.
  always_comb begin
    prod_ready = (state_q == ACCUM) && !clear;
    accept     = prod_valid && prod_ready;
    len_frame  = (frame_len == 8'd0) ? 9'd256 : {1'b0, frame_len};
    len_eff    = (term_cnt_q == 9'd0) ? len_frame : len_q;
    sum_w      = {1'b0, acc_q} + SUM_W'(prod_in);
    ovf        = sum_w[ACC_W];
    next_acc   = ovf ? ACC_MAX : sum_w[ACC_W-1:0];
    last_term  = (term_cnt_q == (len_eff - 9'd1));
  end

  // Next-state logic; clear outranks the handshakes.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    term_cnt_d  = term_cnt_q;
    len_d       = len_q;
    sum_out_d   = sum_out_q;
    sum_valid_d = sum_valid_q;
    sat_d       = sat_q;
    sat_acc_d   = sat_acc_q;

    if (clear) begin
      state_d     = ACCUM;
      acc_d       = '0;
      term_cnt_d  = '0;
      sat_acc_d   = 1'b0;
      sum_valid_d = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            if (term_cnt_q == 9'd0) len_d = len_frame;
            if (last_term) begin
              sum_out_d   = next_acc;
              sat_d       = sat_acc_q | ovf;
              sum_valid_d = 1'b1;
              state_d     = HOLD;
              acc_d       = '0;
              term_cnt_d  = '0;
              sat_acc_d   = 1'b0;
            end else begin
              acc_d       = next_acc;
              term_cnt_d  = term_cnt_q + 9'd1;
              sat_acc_d   = sat_acc_q | ovf;
            end
          end
        end
        HOLD: begin
          if (sum_valid_q && sum_ready) begin
            sum_valid_d = 1'b0;
            state_d     = ACCUM;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      term_cnt_q  <= '0;
      len_q       <= '0;
      sum_out_q   <= '0;
      sum_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      sat_acc_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      term_cnt_q  <= term_cnt_d;
      len_q       <= len_d;
      sum_out_q   <= sum_out_d;
      sum_valid_q <= sum_valid_d;
      sat_q       <= sat_d;
      sat_acc_q   <= sat_acc_d;
    end
  end

  assign sum_out   = sum_out_q;
  assign sum_valid = sum_valid_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: expected sums are hand-computed constants.
module tb_product_accumulator;

  logic        clk;
  logic        reset;
  logic [15:0] prod_in;
  logic        prod_valid;
  logic        prod_ready;
  logic [7:0]  frame_len;
  logic        clear;
  logic [19:0] sum_out;
  logic        sum_valid;
  logic        sum_ready;
  logic        sat;

  int checks;
  int failures;

  product_accumulator #(.ACC_W(20)) dut (
    .clk        (clk),
    .reset      (reset),
    .prod_in    (prod_in),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .frame_len  (frame_len),
    .clear      (clear),
    .sum_out    (sum_out),
    .sum_valid  (sum_valid),
    .sum_ready  (sum_ready),
    .sat        (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are driven and registered outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ready(input string tag, input logic exp);
    @(negedge clk);
    check(tag, 32'(prod_ready), 32'(exp));
  endtask

  task automatic send(input logic [7:0] len, input logic [15:0] val, input int n);
    for (int i = 0; i < n; i++) begin
      prod_valid = 1'b1;
      prod_in    = val;
      frame_len  = len;
      tick();
    end
    prod_valid = 1'b0;
  endtask

  // Send a frame, check the presented sum, then let the consumer take it.
  task automatic frame(input string tag, input logic [7:0] len, input logic [15:0] val,
                       input int n, input logic [19:0] exp_sum, input logic exp_sat);
    sum_ready = 1'b1;
    send(len, val, n);
    check({tag, "_valid"}, 32'(sum_valid), 32'd1);
    check({tag, "_sum"}, 32'(sum_out), 32'(exp_sum));
    check({tag, "_sat"}, 32'(sat), 32'(exp_sat));
    tick();
    check({tag, "_drop"}, 32'(sum_valid), 32'd0);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    prod_in    = '0;
    prod_valid = 1'b0;
    frame_len  = '0;
    clear      = 1'b0;
    sum_ready  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_valid", 32'(sum_valid), 32'd0);
    check("rst_sum", 32'(sum_out), 32'd0);
    check("rst_sat", 32'(sat), 32'd0);
    check_ready("rst_ready", 1'b1);

    // Four distinct terms, back-to-back.
    sum_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      prod_valid = 1'b1;
      prod_in    = 16'(i);
      frame_len  = 8'd4;
      tick();
      if (i == 3) check("f4_not_early", 32'(sum_valid), 32'd0);
    end
    prod_valid = 1'b0;
    check("f4_valid", 32'(sum_valid), 32'd1);
    check("f4_sum", 32'(sum_out), 32'h0000A);
    check("f4_sat", 32'(sat), 32'd0);
    check_ready("f4_hold_ready", 1'b0);
    tick();
    check("f4_drop", 32'(sum_valid), 32'd0);
    check_ready("f4_ready_again", 1'b1);

    // Largest non-saturating frame, then one term more, then sticky flag cleared.
    frame("f16", 8'd16, 16'hFE01, 16, 20'hFE010, 1'b0);
    frame("f17", 8'd17, 16'hFE01, 17, 20'hFFFFF, 1'b1);
    frame("f3", 8'd3, 16'h0002, 3, 20'h00006, 1'b0);

    // frame_len 0 means 256 terms; mid-frame frame_len changes are ignored.
    sum_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      prod_valid = 1'b1;
      prod_in    = 16'h0001;
      frame_len  = (i == 0) ? 8'd0 : 8'(i % 7 + 1);
      tick();
      if (i == 254) check("f256_not_early", 32'(sum_valid), 32'd0);
    end
    prod_valid = 1'b0;
    check("f256_valid", 32'(sum_valid), 32'd1);
    check("f256_sum", 32'(sum_out), 32'h00100);
    tick();
    check("f256_drop", 32'(sum_valid), 32'd0);

    // Backpressure: sum held while the next product waits.
    sum_ready = 1'b0;
    send(8'd2, 16'h0010, 2);
    prod_valid = 1'b1;
    prod_in    = 16'h0007;
    frame_len  = 8'd1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(sum_valid), 32'd1);
      check("bp_sum", 32'(sum_out), 32'h00020);
      check_ready("bp_ready", 1'b0);
      tick();
    end
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    check("bp_release", 32'(sum_valid), 32'd0);
    check_ready("bp_ready_again", 1'b1);
    tick();
    prod_valid = 1'b0;
    check("bp_next_valid", 32'(sum_valid), 32'd1);
    check("bp_next_sum", 32'(sum_out), 32'h00007);
    sum_ready = 1'b1;
    tick();
    check("bp_next_drop", 32'(sum_valid), 32'd0);

    // clear mid-frame with a product offered: partial sum discarded.
    send(8'd4, 16'h0009, 2);
    clear      = 1'b1;
    prod_valid = 1'b1;
    prod_in    = 16'h0009;
    check_ready("clr_ready", 1'b0);
    tick();
    clear      = 1'b0;
    prod_valid = 1'b0;
    check("clr_valid", 32'(sum_valid), 32'd0);
    frame("clr_f4", 8'd4, 16'h0005, 4, 20'h00014, 1'b0);

    // clear in HOLD: sum dropped, value retained.
    sum_ready = 1'b0;
    send(8'd1, 16'h0003, 1);
    check("clrh_valid", 32'(sum_valid), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clrh_drop", 32'(sum_valid), 32'd0);
    check("clrh_keep", 32'(sum_out), 32'h00003);
    check_ready("clrh_ready", 1'b1);

    // reset mid-frame.
    send(8'd4, 16'h0100, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstm_valid", 32'(sum_valid), 32'd0);
    check("rstm_sum", 32'(sum_out), 32'd0);
    check("rstm_sat", 32'(sat), 32'd0);
    check_ready("rstm_ready", 1'b1);

    // reset in HOLD with a saturated sum presented.
    sum_ready = 1'b0;
    send(8'd17, 16'hFE01, 17);
    check("rsth_pre_sat", 32'(sat), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rsth_valid", 32'(sum_valid), 32'd0);
    check("rsth_sum", 32'(sum_out), 32'd0);
    check("rsth_sat", 32'(sat), 32'd0);
    check_ready("rsth_ready", 1'b1);
    frame("rst_f1", 8'd1, 16'h1234, 1, 20'h01234, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
